// File: rtl/alarm_annunciator.sv
// Turns one level alarm request into a latched, operator-acknowledged alarm.
// Drives buzzer, blinking lamp and a late-acknowledge escalation flag.
module alarm_annunciator #(
  parameter int BLINK_HALF = 25,
  parameter int ESC_CYCLES = 250,
  parameter int DEB_CYCLES = 10
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       alarm_req,
  input  logic       ack,
  output logic       buzzer,
  output logic       lamp,
  output logic       escalate,
  output logic [1:0] state,
  output logic [7:0] alarm_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALERT = 2'd1;
  localparam logic [1:0] S_ACKED = 2'd2;

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int EW = $clog2(ESC_CYCLES + 1);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [EW-1:0] ESC_MAX    = EW'(ESC_CYCLES);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);

  logic          req_s1, req_s;
  logic          ack_s1, ack_s;
  logic          db, db_q;
  logic [DW-1:0] deb_cnt;
  logic          ack_rise;

  logic [1:0]    state_q;
  logic [BW-1:0] blink_cnt;
  logic [EW-1:0] esc_cnt;
  logic          lamp_q;

  // Synchronizers and debouncer; db only changes after DEB_CYCLES
  // consecutive differing samples, so short bounces are absorbed.
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      req_s1  <= 1'b0;
      req_s   <= 1'b0;
      ack_s1  <= 1'b0;
      ack_s   <= 1'b0;
      db      <= 1'b0;
      db_q    <= 1'b0;
      deb_cnt <= '0;
    end else begin
      req_s1 <= alarm_req;
      req_s  <= req_s1;
      ack_s1 <= ack;
      ack_s  <= ack_s1;
      db_q   <= db;
      if (ack_s == db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        db      <= ack_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign ack_rise = db & ~db_q;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      alarm_count <= '0;
      blink_cnt   <= '0;
      esc_cnt     <= '0;
      lamp_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_s) begin
            state_q   <= S_ALERT;
            blink_cnt <= '0;
            esc_cnt   <= '0;
            lamp_q    <= 1'b1;
            if (alarm_count != 8'hFF) alarm_count <= alarm_count + 1'b1;
          end
        end
        S_ALERT: begin
          // Acknowledge wins over blink/escalation; req_s is ignored (latched).
          if (ack_rise) begin
            state_q <= S_ACKED;
          end else begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              lamp_q    <= ~lamp_q;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
            if (esc_cnt != ESC_MAX) esc_cnt <= esc_cnt + 1'b1;
          end
        end
        S_ACKED: begin
          if (!req_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    buzzer   = 1'b0;
    lamp     = 1'b0;
    escalate = 1'b0;
    case (state_q)
      S_ALERT: begin
        buzzer   = 1'b1;
        lamp     = lamp_q;
        escalate = (esc_cnt == ESC_MAX);
      end
      S_ACKED: lamp = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed bench for alarm_annunciator with BLINK_HALF=4, ESC_CYCLES=20, DEB_CYCLES=3.
module tb_alarm_annunciator;

  logic       clk_2;
  logic       reset;
  logic       alarm_req;
  logic       ack;
  logic       buzzer;
  logic       lamp;
  logic       escalate;
  logic [1:0] state;
  logic [7:0] alarm_count;

  logic [12:0] obs;
  logic [12:0] exp_v;
  logic        lamp_e;
  logic        esc_e;
  int          n_cmp;
  int          n_err;

  alarm_annunciator #(
    .BLINK_HALF(4),
    .ESC_CYCLES(20),
    .DEB_CYCLES(3)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .alarm_req  (alarm_req),
    .ack        (ack),
    .buzzer     (buzzer),
    .lamp       (lamp),
    .escalate   (escalate),
    .state      (state),
    .alarm_count(alarm_count)
  );

  assign obs = {buzzer, lamp, escalate, state, alarm_count};

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    alarm_req = 1'b0;
    ack = 1'b0;
    cyc(3);
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", obs, 13'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      n_cmp++;
      if (obs !== 13'd0) begin
        n_err++;
        $display("FAIL idle_%0d: got %h expected %h", i, obs, 13'd0);
      end
    end
  endtask

  task automatic test_alarm_blink;
    alarm_req = 1'b1;
    cyc(2);
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++;
      $display("FAIL alarm_latency: got %h expected %h", obs, 13'd0);
    end
    cyc(1);
    for (int j = 0; j < 16; j++) begin
      lamp_e = ((j / 4) % 2 == 0);
      exp_v = {1'b1, lamp_e, 1'b0, 2'd1, 8'd1};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL blink_%0d: got %h expected %h", j, obs, exp_v);
      end
      cyc(1);
    end
  endtask

  task automatic test_ack_clear;
    ack = 1'b1;
    cyc(5);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++;
      $display("FAIL ack_latency: got %b expected %b", {buzzer, state}, 3'b101);
    end
    cyc(1);
    exp_v = {1'b0, 1'b1, 1'b0, 2'd2, 8'd1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL acked: got %h expected %h", obs, exp_v);
    end
    alarm_req = 1'b0;
    cyc(2);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL clear_latency: got %h expected %h", obs, exp_v);
    end
    cyc(1);
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL cleared: got %h expected %h", obs, exp_v);
    end
    ack = 1'b0;
    cyc(8);
  endtask

  task automatic test_bounce;
    alarm_req = 1'b1;
    cyc(3);
    exp_v = {1'b1, 1'b1, 1'b0, 2'd1, 8'd2};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL bounce_entry: got %h expected %h", obs, exp_v);
    end
    for (int k = 0; k < 5; k++) begin
      ack = (k % 2 == 0) && (k < 4);
      for (int c = 0; c < ((k < 4) ? 2 : 6); c++) begin
        cyc(1);
        n_cmp++;
        if ({buzzer, state} !== 3'b101) begin
          n_err++;
          $display("FAIL bounce_%0d_%0d: got %b expected %b", k, c, {buzzer, state}, 3'b101);
        end
      end
    end
    ack = 1'b1;
    cyc(6);
    exp_v = {1'b0, 1'b1, 1'b0, 2'd2, 8'd2};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL bounce_ack: got %h expected %h", obs, exp_v);
    end
    alarm_req = 1'b0;
    ack = 1'b0;
    cyc(8);
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 8'd2};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL bounce_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_escalation;
    alarm_req = 1'b1;
    cyc(3);
    for (int j = 0; j < 25; j++) begin
      lamp_e = ((j / 4) % 2 == 0);
      esc_e = (j >= 20);
      exp_v = {1'b1, lamp_e, esc_e, 2'd1, 8'd3};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL escalate_%0d: got %h expected %h", j, obs, exp_v);
      end
      // Request is high for exactly 5 sampled edges.
      if (j == 2) alarm_req = 1'b0;
      cyc(1);
    end
    ack = 1'b1;
    cyc(5);
    n_cmp++;
    if ({escalate, state} !== 3'b101) begin
      n_err++;
      $display("FAIL escalate_hold: got %b expected %b", {escalate, state}, 3'b101);
    end
    cyc(1);
    exp_v = {1'b0, 1'b1, 1'b0, 2'd2, 8'd3};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL escalate_ack: got %h expected %h", obs, exp_v);
    end
    cyc(1);
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 8'd3};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL escalate_idle: got %h expected %h", obs, exp_v);
    end
    ack = 1'b0;
    cyc(8);
  endtask

  task automatic test_ack_held;
    ack = 1'b1;
    cyc(8);
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 8'd3};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL held_idle: got %h expected %h", obs, exp_v);
    end
    alarm_req = 1'b1;
    cyc(3);
    exp_v = {1'b1, 1'b1, 1'b0, 2'd1, 8'd4};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL held_entry: got %h expected %h", obs, exp_v);
    end
    cyc(10);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++;
      $display("FAIL held_stay: got %b expected %b", {buzzer, state}, 3'b101);
    end
    ack = 1'b0;
    cyc(6);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++;
      $display("FAIL held_release: got %b expected %b", {buzzer, state}, 3'b101);
    end
    ack = 1'b1;
    cyc(6);
    exp_v = {1'b0, 1'b1, 1'b0, 2'd2, 8'd4};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL held_repress: got %h expected %h", obs, exp_v);
    end
    alarm_req = 1'b0;
    ack = 1'b0;
    cyc(8);
  endtask

  task automatic test_back_to_back;
    alarm_req = 1'b1;
    cyc(3);
    exp_v = {1'b1, 1'b1, 1'b0, 2'd1, 8'd5};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_entry: got %h expected %h", obs, exp_v);
    end
    ack = 1'b1;
    cyc(3);
    // req_s falls in the same cycle ack_rise is high.
    alarm_req = 1'b0;
    cyc(2);
    n_cmp++;
    if ({buzzer, state} !== 3'b101) begin
      n_err++;
      $display("FAIL b2b_pre: got %b expected %b", {buzzer, state}, 3'b101);
    end
    cyc(1);
    exp_v = {1'b0, 1'b1, 1'b0, 2'd2, 8'd5};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_acked: got %h expected %h", obs, exp_v);
    end
    cyc(1);
    exp_v = {1'b0, 1'b0, 1'b0, 2'd0, 8'd5};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL b2b_idle: got %h expected %h", obs, exp_v);
    end
    ack = 1'b0;
    cyc(8);
  endtask

  task automatic test_saturation;
    logic [7:0] exp_cnt;
    for (int i = 0; i < 300; i++) begin
      alarm_req = 1'b1;
      cyc(3);
      exp_cnt = (6 + i > 255) ? 8'd255 : 8'(6 + i);
      n_cmp++;
      if (alarm_count !== exp_cnt) begin
        n_err++;
        $display("FAIL sat_count_%0d: got %0d expected %0d", i, alarm_count, exp_cnt);
      end
      ack = 1'b1;
      cyc(6);
      alarm_req = 1'b0;
      ack = 1'b0;
      cyc(6);
    end
  endtask

  task automatic test_async_reset;
    alarm_req = 1'b1;
    cyc(3);
    exp_v = {1'b1, 1'b1, 1'b0, 2'd1, 8'd255};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL sat_alert: got %h expected %h", obs, exp_v);
    end
    #3;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h", obs, 13'd0);
    end
    cyc(1);
    reset = 1'b1;
    cyc(2);
    n_cmp++;
    if (obs !== 13'd0) begin
      n_err++;
      $display("FAIL post_reset_sync: got %h expected %h", obs, 13'd0);
    end
    cyc(1);
    exp_v = {1'b1, 1'b1, 1'b0, 2'd1, 8'd1};
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL post_reset_alert: got %h expected %h", obs, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset;
    test_alarm_blink;
    test_ack_clear;
    test_bounce;
    test_escalation;
    test_ack_held;
    test_back_to_back;
    test_saturation;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
